// File: rtl/pe_mc_if.sv
// ============================================================================
// pe_mc_if : multicast bus-to-PE handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pe_mc_if #(
  parameter int DATA_SIZE = 32,
  parameter int ID_SIZE   = 5
);
  logic                 in_enable;
  logic                 in_ready;
  logic [ID_SIZE-1:0]   tag;
  logic [DATA_SIZE-1:0] data_in;
  logic                 out_enable;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] data_out;

  // Upstream bus source and downstream PE sink, seen from outside the block
  modport master (
    output in_enable, tag, data_in, out_ready,
    input  in_ready, out_enable, data_out
  );

  modport slave (
    input  in_enable, tag, data_in, out_ready,
    output in_ready, out_enable, data_out
  );
endinterface

`default_nettype wire

// File: rtl/pe_mc.sv
// ============================================================================
// pe_mc : multicast filter with FIFO buffering toward a PE port.
// Optional macro MC_STAT_EN adds the fwd_cnt pop counter.   Rev 1.0
// ============================================================================
`default_nettype none

module pe_mc #(
  parameter int DATA_SIZE  = 32,
  parameter int ID_SIZE    = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               set_id,
  input  wire logic [ID_SIZE-1:0] id_in,
  pe_mc_if.slave                  bus
`ifdef MC_STAT_EN
  ,
  output logic [15:0]             fwd_cnt
`endif
);

  localparam int c_addr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_addr_w:0] c_full_cnt = (c_addr_w + 1)'(FIFO_DEPTH);

  logic [ID_SIZE-1:0]   r_id;
  logic [c_addr_w-1:0]  r_wptr;
  logic [c_addr_w-1:0]  r_rptr;
  logic [c_addr_w:0]    r_count;
  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];

  logic w_match;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_match = (bus.tag == r_id) || (bus.tag == {ID_SIZE{1'b1}});
  assign w_full  = (r_count == c_full_cnt);
  assign w_empty = (r_count == '0);

  // Non-matching words are always accepted and dropped; readiness never
  // looks at out_ready, so a full FIFO stalls even when a pop is in flight.
  assign bus.in_ready   = !w_match || !w_full;
  assign w_push         = bus.in_enable && w_match && !w_full;
  assign w_pop          = !w_empty && bus.out_ready;
  assign bus.out_enable = !w_empty;
  assign bus.data_out   = w_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (set_id) begin
        r_id <= id_in;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.data_in;
    end
  end

`ifdef MC_STAT_EN
  logic [15:0] r_fwd_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fwd_cnt <= '0;
    end else if (set_id) begin
      r_fwd_cnt <= '0;
    end else if (w_pop) begin
      r_fwd_cnt <= r_fwd_cnt + 16'd1;
    end
  end

  assign fwd_cnt = r_fwd_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pe_mc.sv
// Self-checking bench for pe_mc against a queue-based reference model.
`default_nettype none

module tb_pe_mc;
  localparam int DW    = 32;
  localparam int IW    = 5;
  localparam int DEPTH = 4;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          set_id = 1'b0;
  logic [IW-1:0] id_in  = '0;
`ifdef MC_STAT_EN
  logic [15:0]   fwd_cnt;
`endif

  pe_mc_if #(.DATA_SIZE(DW), .ID_SIZE(IW)) bus ();

  pe_mc #(.DATA_SIZE(DW), .ID_SIZE(IW), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .set_id (set_id),
    .id_in  (id_in),
    .bus    (bus)
`ifdef MC_STAT_EN
    ,
    .fwd_cnt(fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] q[$];
  logic [IW-1:0] m_id;
  int            m_cnt;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check before the edge, advance the model at the edge
  task automatic cycle(input logic en, input logic [IW-1:0] t, input logic [DW-1:0] d,
                       input logic ordy, input logic sid, input logic [IW-1:0] nid);
    logic match, exp_rdy, pop, push;
    bus.in_enable = en;
    bus.tag       = t;
    bus.data_in   = d;
    bus.out_ready = ordy;
    set_id        = sid;
    id_in         = nid;
    @(negedge clk);
    match   = (t == m_id) || (t == {IW{1'b1}});
    exp_rdy = !match || (q.size() < DEPTH);
    check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    check("out_enable", 32'(bus.out_enable), 32'(q.size() > 0));
    if (q.size() > 0) check("data_out", bus.data_out, q[0]);
`ifdef MC_STAT_EN
    check("fwd_cnt", 32'(fwd_cnt), 32'(m_cnt));
`endif
    pop  = (q.size() > 0) && ordy;
    push = en && match && (q.size() < DEPTH);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    if (sid) begin
      m_id  = nid;
      m_cnt = 0;
    end else if (pop) begin
      m_cnt = (m_cnt + 1) & 32'hFFFF;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, ordy, 1'b0, '0);
  endtask

  task automatic reset_checks(input string who);
    check({who, "_out_enable"}, 32'(bus.out_enable), 32'd0);
    check({who, "_data_out"}, bus.data_out, 32'd0);
    bus.tag = IW'($urandom);
    #1;
    check({who, "_in_ready"}, 32'(bus.in_ready), 32'd1);
`ifdef MC_STAT_EN
    check({who, "_fwd_cnt"}, 32'(fwd_cnt), 32'd0);
`endif
  endtask

  initial begin
    bus.in_enable = 1'b0;
    bus.tag       = '0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    m_id  = '0;
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    #1;

    // Configure and forward a single word
    cycle(1'b0, '0, '0, 1'b1, 1'b1, 5'd3);
    cycle(1'b1, 5'd3, 32'h11223344, 1'b1, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    // Filtering and broadcast
    cycle(1'b1, 5'd5, 32'hAA, 1'b1, 1'b0, '0);
    cycle(1'b1, 5'h1F, 32'hBB, 1'b1, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: fifth word stalls until the PE drains
    for (int i = 1; i <= 5; i++) cycle(1'b1, 5'd3, DW'(i), 1'b0, 1'b0, '0);
    cycle(1'b1, 5'd3, 32'd5, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Full FIFO with simultaneous pop still stalls the matching word
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd3, 32'h100 + DW'(i), 1'b0, 1'b0, '0);
    cycle(1'b1, 5'd3, 32'h1FF, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Concurrent push/pop with pointer wrap
    for (int i = 0; i < 20; i++) cycle(1'b1, 5'd3, 32'h200 + DW'(i), 1'(i % 2 == 0), 1'b0, '0);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // set_id does not touch buffered data; same-cycle transfer uses old ID
    cycle(1'b1, 5'd3, 32'hC0DE, 1'b0, 1'b0, '0);
    cycle(1'b1, 5'd3, 32'hC0DF, 1'b0, 1'b1, 5'd7);
    cycle(1'b1, 5'd3, 32'hDEAD, 1'b0, 1'b0, '0);
    cycle(1'b1, 5'd7, 32'hBEEF, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Reset mid-stream with three words buffered
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd7, 32'h300 + DW'(i), 1'b0, 1'b0, '0);
    bus.in_enable = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    q.delete();
    m_id  = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 5'd0, 32'h0BAD, 1'b0, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);

    // Six pops then set_id clears the statistics counter
    for (int i = 0; i < 6; i++) cycle(1'b1, 5'd0, 32'h400 + DW'(i), 1'b1, 1'b0, '0);
    idle(1'b1);
    idle(1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, 5'd9);
    idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [IW-1:0] t;
      int sel;
      sel = int'($urandom_range(0, 3));
      t = (sel == 0) ? IW'($urandom) : (sel == 1) ? {IW{1'b1}} : m_id;
      cycle(1'($urandom), t, $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 40) == 0), IW'($urandom));
    end
    for (int i = 0; i < 6; i++) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
